// File: rtl/vector_exec_unit.sv
// vector_exec_unit: vector/scalar integer execution unit.
//   Vector mode (exc[4]=1) operates lane-wise on r1v/r2v (LANES x LANE_W,
//   no carry between lanes); scalar mode (exc[4]=0) operates on 21-bit
//   r1e/r2e. Every operation completes in one cycle except vector MUL, which
//   walks the lanes two at a time over four cycles while holding stall high.
// Ports:
//   clk, rst (async, active-low)
//   in_valid, exc[4:0] (mode + opcode), r1e/r2e, r1v/r2v, imm, dest, destType
//   stall        - upstream must hold its inputs while high
//   out_valid    - one-cycle pulse per completed operation
//   res_v, res_e - vector / scalar result, held between pulses
//   dest_out, destType_out - destination tag of the completed operation
module vector_exec_unit #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned LANE_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [4:0]              exc,
    input  logic [20:0]             r1e,
    input  logic [20:0]             r2e,
    input  logic [LANES*LANE_W-1:0] r1v,
    input  logic [LANES*LANE_W-1:0] r2v,
    input  logic [20:0]             imm,
    input  logic [3:0]              dest,
    input  logic                    destType,
    output logic                    stall,
    output logic                    out_valid,
    output logic [LANES*LANE_W-1:0] res_v,
    output logic [20:0]             res_e,
    output logic [3:0]              dest_out,
    output logic                    destType_out
);

    localparam int unsigned SW = 21;
    localparam int unsigned VW = LANES * LANE_W;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_ADDI = 4'd7,
        OP_MUL  = 4'd8,
        OP_PASS = 4'd9
    } op_t;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t            state, state_next;
    logic [1:0]        cnt;
    logic [VW-1:0]     mul_a, mul_b, mul_acc, mul_next;
    logic [3:0]        mul_dest;
    logic              mul_dtype;
    logic [VW-1:0]     vec_res;
    logic [SW-1:0]     scal_res;
    logic [31:0]       pair_lo;
    logic              accept, vmul_start;

    // Single-lane ALU; MUL is handled by the multi-cycle lane-pair path.
    function automatic logic [LANE_W-1:0] lane_alu(
        input logic [3:0]        op,
        input logic [LANE_W-1:0] a,
        input logic [LANE_W-1:0] b,
        input logic [20:0]       im
    );
        logic [31:0]       sh;
        logic [LANE_W-1:0] simm;
        sh   = {27'd0, im[4:0]};
        simm = {{(LANE_W-SW){im[20]}}, im};
        lane_alu = '0;
        case (op)
            OP_ADD:  lane_alu = a + b;
            OP_SUB:  lane_alu = a - b;
            OP_AND:  lane_alu = a & b;
            OP_OR:   lane_alu = a | b;
            OP_XOR:  lane_alu = a ^ b;
            OP_SLL:  lane_alu = (sh >= LANE_W) ? '0 : a << im[4:0];
            OP_SRL:  lane_alu = (sh >= LANE_W) ? '0 : a >> im[4:0];
            OP_ADDI: lane_alu = a + simm;
            OP_PASS: lane_alu = a;
            default: lane_alu = '0;
        endcase
    endfunction

    function automatic logic [SW-1:0] scal_alu(
        input logic [3:0]    op,
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic [20:0]   im
    );
        logic [31:0] sh;
        sh = {27'd0, im[4:0]};
        scal_alu = '0;
        case (op)
            OP_ADD:  scal_alu = a + b;
            OP_SUB:  scal_alu = a - b;
            OP_AND:  scal_alu = a & b;
            OP_OR:   scal_alu = a | b;
            OP_XOR:  scal_alu = a ^ b;
            OP_SLL:  scal_alu = (sh >= SW) ? '0 : a << im[4:0];
            OP_SRL:  scal_alu = (sh >= SW) ? '0 : a >> im[4:0];
            OP_ADDI: scal_alu = a + im;
            OP_MUL:  scal_alu = a * b;
            OP_PASS: scal_alu = a;
            default: scal_alu = '0;
        endcase
    endfunction

    // Acceptance is keyed off the state rather than stall to keep the
    // FSM combinational block free of a feedback path through stall.
    assign accept     = in_valid && (state == IDLE);
    assign vmul_start = accept && exc[4] && (exc[3:0] == OP_MUL);

    always_comb begin
        vec_res = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            vec_res[i*LANE_W +: LANE_W] = lane_alu(exc[3:0], r1v[i*LANE_W +: LANE_W],
                                                   r2v[i*LANE_W +: LANE_W], imm);
        end
        scal_res = scal_alu(exc[3:0], r1e, r2e, imm);
    end

    // Two multipliers shared across the lanes, selected by the pair counter.
    always_comb begin
        pair_lo  = 32'(cnt) * 32'd2 * LANE_W;
        mul_next = mul_acc;
        mul_next[pair_lo +: LANE_W] =
            mul_a[pair_lo +: LANE_W] * mul_b[pair_lo +: LANE_W];
        mul_next[pair_lo + LANE_W +: LANE_W] =
            mul_a[pair_lo + LANE_W +: LANE_W] * mul_b[pair_lo + LANE_W +: LANE_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: if (vmul_start) state_next = MUL;
            MUL: begin
                stall = 1'b1;
                if (cnt == 2'd3) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_acc      <= '0;
            mul_dest     <= '0;
            mul_dtype    <= 1'b0;
            out_valid    <= 1'b0;
            res_v        <= '0;
            res_e        <= '0;
            dest_out     <= '0;
            destType_out <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == MUL) begin
                cnt     <= cnt + 2'd1;
                mul_acc <= mul_next;
                if (cnt == 2'd3) begin
                    out_valid    <= 1'b1;
                    res_v        <= mul_next;
                    res_e        <= '0;
                    dest_out     <= mul_dest;
                    destType_out <= mul_dtype;
                end
            end else if (accept) begin
                if (vmul_start) begin
                    cnt       <= '0;
                    mul_a     <= r1v;
                    mul_b     <= r2v;
                    mul_dest  <= dest;
                    mul_dtype <= destType;
                end else begin
                    out_valid    <= 1'b1;
                    dest_out     <= dest;
                    destType_out <= destType;
                    if (exc[4]) begin
                        res_v <= vec_res;
                        res_e <= '0;
                    end else begin
                        res_v <= '0;
                        res_e <= scal_res;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_exec_unit.sv
// tb_vector_exec_unit: randomized self-checking bench for vector_exec_unit
// against an arithmetic reference model of the lane/scalar operations.
module tb_vector_exec_unit;

    localparam int LANES = 8;
    localparam int LW    = 24;
    localparam int VW    = LANES * LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [4:0]    exc;
    logic [20:0]   r1e, r2e, imm;
    logic [VW-1:0] r1v, r2v;
    logic [3:0]    dest;
    logic          destType;
    logic          stall, out_valid;
    logic [VW-1:0] res_v;
    logic [20:0]   res_e;
    logic [3:0]    dest_out;
    logic          destType_out;

    int n_checks = 0;
    int n_fail   = 0;

    vector_exec_unit #(.LANES(LANES), .LANE_W(LW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .exc(exc),
        .r1e(r1e), .r2e(r2e), .r1v(r1v), .r2v(r2v), .imm(imm),
        .dest(dest), .destType(destType), .stall(stall), .out_valid(out_valid),
        .res_v(res_v), .res_e(res_e), .dest_out(dest_out), .destType_out(destType_out)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic modulo 2^w.
    function automatic longint ref_op(int w, int op, longint a, longint b, longint im);
        longint m, sh, simm;
        m    = longint'(1) << w;
        sh   = im % 32;
        simm = (im >= (longint'(1) << 20)) ? im - (longint'(1) << 21) : im;
        case (op)
            0: return (a + b) % m;
            1: return (a - b + m) % m;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (sh >= w) ? 0 : (a * (longint'(1) << sh)) % m;
            6: return (sh >= w) ? 0 : a / (longint'(1) << sh);
            7: return (((a + simm) % m) + m) % m;
            8: return (a * b) % m;
            9: return a;
            default: return 0;
        endcase
    endfunction

    function automatic logic [VW-1:0] ref_vec(int op, logic [VW-1:0] a, logic [VW-1:0] b,
                                              logic [20:0] im);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*LW +: LW] = LW'(ref_op(LW, op, longint'(a[i*LW +: LW]),
                                       longint'(b[i*LW +: LW]), longint'(im)));
        return r;
    endfunction

    function automatic logic [20:0] ref_scal(int op, logic [20:0] a, logic [20:0] b,
                                             logic [20:0] im);
        return 21'(ref_op(21, op, longint'(a), longint'(b), longint'(im)));
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic put(input bit v, input logic [4:0] e, input logic [20:0] a1e,
                       input logic [20:0] a2e, input logic [VW-1:0] a1v,
                       input logic [VW-1:0] a2v, input logic [20:0] im,
                       input logic [3:0] d, input logic dt);
        @(negedge clk);
        in_valid = v; exc = e; r1e = a1e; r2e = a2e; r1v = a1v; r2v = a2v;
        imm = im; dest = d; destType = dt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        put(1'b1, 5'h10, 21'h1, 21'h2, rand_vec(), rand_vec(), 21'h3, 4'hF, 1'b1);
        step();
        step();
        n_checks++;
        if ({out_valid, stall} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 00", {out_valid, stall});
        end
        n_checks++;
        if ({res_v, res_e, dest_out, destType_out} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0",
                               {res_v, res_e, dest_out, destType_out});
        end
        put(1'b0, 5'h0, '0, '0, '0, '0, '0, 4'h0, 1'b0);
        rst = 1'b1;
    endtask

    task automatic test_vec_add_carry();
        put(1'b1, 5'h10, 21'h0, 21'h0, {LANES{24'hFFFFFF}}, {LANES{24'h000001}},
            21'h0, 4'h3, 1'b1);
        step();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL vadd_valid: got %b expected 1", out_valid);
        end
        n_checks++;
        if ({res_v, res_e} !== '0) begin
            n_fail++; $display("FAIL vadd_carry: got %h expected 0", {res_v, res_e});
        end
        n_checks++;
        if ({dest_out, destType_out} !== {4'h3, 1'b1}) begin
            n_fail++; $display("FAIL vadd_dest: got %h expected 7", {dest_out, destType_out});
        end
    endtask

    task automatic test_scalar_sub();
        put(1'b1, 5'h01, 21'h0, 21'h1, rand_vec(), rand_vec(), 21'h0, 4'h5, 1'b0);
        step();
        n_checks++;
        if ({out_valid, res_e} !== {1'b1, 21'h1FFFFF}) begin
            n_fail++; $display("FAIL ssub: got %b %h expected 1 1fffff", out_valid, res_e);
        end
        n_checks++;
        if (res_v !== '0) begin
            n_fail++; $display("FAIL ssub_resv: got %h expected 0", res_v);
        end
    endtask

    task automatic test_vec_mul();
        logic [VW-1:0] a, expv;
        for (int i = 0; i < LANES; i++) begin
            a[i*LW +: LW]    = LW'(i + 1);
            expv[i*LW +: LW] = LW'((i + 1) * (i + 1));
        end
        put(1'b1, 5'h18, 21'h0, 21'h0, a, a, 21'h0, 4'hA, 1'b1);
        step();
        put(1'b0, 5'h10, 21'h0, 21'h0, rand_vec(), rand_vec(), 21'h0, 4'h5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            n_checks++;
            if ({stall, out_valid} !== 2'b10) begin
                n_fail++; $display("FAIL vmul_stall cyc%0d: got %b expected 10", k,
                                   {stall, out_valid});
            end
        end
        step();
        n_checks++;
        if ({stall, out_valid} !== 2'b01) begin
            n_fail++; $display("FAIL vmul_done: got %b expected 01", {stall, out_valid});
        end
        n_checks++;
        if (res_v !== expv) begin
            n_fail++; $display("FAIL vmul_res: got %h expected %h", res_v, expv);
        end
        n_checks++;
        if ({dest_out, destType_out, res_e} !== {4'hA, 1'b1, 21'h0}) begin
            n_fail++; $display("FAIL vmul_dest: got %h %b expected a 1", dest_out, destType_out);
        end
        // Issue immediately after completion: must be accepted.
        put(1'b1, 5'h00, 21'd100, 21'd23, '0, '0, 21'h0, 4'h2, 1'b0);
        step();
        n_checks++;
        if ({out_valid, res_e, dest_out} !== {1'b1, 21'd123, 4'h2}) begin
            n_fail++; $display("FAIL vmul_next: got %b %0d %h expected 1 123 2",
                               out_valid, res_e, dest_out);
        end
    endtask

    task automatic test_mul_reset();
        logic [VW-1:0] a, b;
        a = rand_vec(); b = rand_vec();
        put(1'b1, 5'h18, 21'h0, 21'h0, a, b, 21'h0, 4'h9, 1'b1);
        step();
        put(1'b0, 5'h0, '0, '0, '0, '0, '0, 4'h0, 1'b0);
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, stall, res_v, res_e, dest_out, destType_out} !== '0) begin
            n_fail++; $display("FAIL mulrst_outs: got %b %b %h %h %h %b expected 0",
                               out_valid, stall, res_v, res_e, dest_out, destType_out);
        end
        step();
        n_checks++;
        if ({out_valid, stall} !== 2'b00) begin
            n_fail++; $display("FAIL mulrst_hold: got %b expected 00", {out_valid, stall});
        end
        @(negedge clk);
        rst = 1'b1;
        a = rand_vec(); b = rand_vec();
        put(1'b1, 5'h10, 21'h0, 21'h0, a, b, 21'h0, 4'h6, 1'b0);
        step();
        n_checks++;
        if ({out_valid, res_v} !== {1'b1, ref_vec(0, a, b, 21'h0)}) begin
            n_fail++; $display("FAIL mulrst_add: got %b %h expected 1 %h", out_valid, res_v,
                               ref_vec(0, a, b, 21'h0));
        end
        put(1'b0, 5'h0, '0, '0, '0, '0, '0, 4'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({out_valid, stall} !== 2'b00) begin
                n_fail++; $display("FAIL mulrst_stray cyc%0d: got %b expected 00", k,
                                   {out_valid, stall});
            end
        end
    endtask

    task automatic test_addi_sll();
        put(1'b1, 5'h17, 21'h0, 21'h0, {LANES{24'd5}}, rand_vec(), 21'h1FFFFF, 4'h1, 1'b0);
        step();
        n_checks++;
        if ({out_valid, res_v} !== {1'b1, {LANES{24'd4}}}) begin
            n_fail++; $display("FAIL vaddi: got %b %h expected 1 all-4", out_valid, res_v);
        end
        put(1'b1, 5'h15, 21'h0, 21'h0, {LANES{24'hFFFFFF}}, rand_vec(), 21'd24, 4'h1, 1'b0);
        step();
        n_checks++;
        if ({out_valid, res_v} !== {1'b1, {VW{1'b0}}}) begin
            n_fail++; $display("FAIL vsll24: got %b %h expected 1 0", out_valid, res_v);
        end
        put(1'b1, 5'h15, 21'h0, 21'h0, {LANES{24'h000001}}, rand_vec(), 21'd23, 4'h1, 1'b0);
        step();
        n_checks++;
        if (res_v !== {LANES{24'h800000}}) begin
            n_fail++; $display("FAIL vsll23: got %h expected all-800000", res_v);
        end
        put(1'b1, 5'h05, 21'h1, 21'h0, '0, '0, 21'd21, 4'h1, 1'b0);
        step();
        n_checks++;
        if ({out_valid, res_e} !== {1'b1, 21'h0}) begin
            n_fail++; $display("FAIL ssll21: got %b %h expected 1 0", out_valid, res_e);
        end
        put(1'b1, 5'h05, 21'h1, 21'h0, '0, '0, 21'd20, 4'h1, 1'b0);
        step();
        n_checks++;
        if (res_e !== 21'h100000) begin
            n_fail++; $display("FAIL ssll20: got %h expected 100000", res_e);
        end
    endtask

    task automatic test_reserved_and_toggle();
        put(1'b1, 5'h1C, 21'h1234, 21'h55, rand_vec(), rand_vec(), 21'h7, 4'h4, 1'b1);
        step();
        n_checks++;
        if ({out_valid, res_v, res_e, dest_out} !== {1'b1, {VW{1'b0}}, 21'h0, 4'h4}) begin
            n_fail++; $display("FAIL resv_vec: got %b %h %h %h expected 1 0 0 4",
                               out_valid, res_v, res_e, dest_out);
        end
        put(1'b1, 5'h0F, 21'h1234, 21'h55, rand_vec(), rand_vec(), 21'h7, 4'h4, 1'b1);
        step();
        n_checks++;
        if ({out_valid, res_e} !== {1'b1, 21'h0}) begin
            n_fail++; $display("FAIL resv_scal: got %b %h expected 1 0", out_valid, res_e);
        end
        put(1'b1, 5'h18, 21'h0, 21'h0, rand_vec(), rand_vec(), 21'h0, 4'h8, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            put(k[0] ? 1'b0 : 1'b1, 5'h00, 21'h1, 21'h1, '0, '0, 21'h0, 4'hC, 1'b1);
            step();
            n_checks++;
            if (out_valid !== (k == 3)) begin
                n_fail++; $display("FAIL toggle cyc%0d: got %b expected %b", k, out_valid,
                                   (k == 3));
            end
        end
        n_checks++;
        if (dest_out !== 4'h8) begin
            n_fail++; $display("FAIL toggle_dest: got %h expected 8", dest_out);
        end
        put(1'b0, 5'h00, 21'h1, 21'h1, '0, '0, 21'h0, 4'hC, 1'b1);
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL toggle_extra: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] a, b, ev;
        logic [20:0]   ae, be, im, ee;
        logic [3:0]    d;
        logic          dt, vec;
        int            op;
        ev = '0; ee = '0; d = '0; dt = 1'b0;
        for (int n = 0; n < 60; n++) begin
            vec = 1'($urandom);
            op  = int'($urandom_range(0, 15));
            if (vec && op == 8) op = 0;
            a = rand_vec(); b = rand_vec();
            ae = 21'($urandom); be = 21'($urandom);
            im = (n % 4 == 0) ? 21'($urandom_range(18, 31)) : 21'($urandom);
            d = 4'($urandom); dt = 1'($urandom);
            put(1'b1, {vec, 4'(op)}, ae, be, a, b, im, d, dt);
            ev = vec ? ref_vec(op, a, b, im) : '0;
            ee = vec ? 21'h0 : ref_scal(op, ae, be, im);
            step();
            n_checks++;
            if ({out_valid, res_v, res_e, dest_out, destType_out} !== {1'b1, ev, ee, d, dt}) begin
                n_fail++; $display("FAIL rand%0d vec=%0d op=%0d: got %b %h %h %h %b expected 1 %h %h %h %b",
                                   n, vec, op, out_valid, res_v, res_e, dest_out, destType_out,
                                   ev, ee, d, dt);
            end
        end
        put(1'b0, 5'h00, 21'($urandom), 21'($urandom), rand_vec(), rand_vec(), 21'h0,
            ~d, ~dt);
        step();
        step();
        n_checks++;
        if ({out_valid, res_v, res_e, dest_out, destType_out} !== {1'b0, ev, ee, d, dt}) begin
            n_fail++; $display("FAIL hold: got %b %h %h %h %b expected 0 %h %h %h %b",
                               out_valid, res_v, res_e, dest_out, destType_out, ev, ee, d, dt);
        end
    endtask

    task automatic test_random_mul();
        logic [VW-1:0] a, b;
        logic [3:0]    d;
        for (int n = 0; n < 4; n++) begin
            a = rand_vec(); b = rand_vec(); d = 4'($urandom);
            put(1'b1, 5'h18, 21'h0, 21'h0, a, b, 21'h0, d, 1'b0);
            step();
            put(1'b0, 5'h18, 21'h0, 21'h0, rand_vec(), rand_vec(), 21'h0, ~d, 1'b1);
            step(); step(); step(); step();
            n_checks++;
            if ({out_valid, res_v, dest_out} !== {1'b1, ref_vec(8, a, b, 21'h0), d}) begin
                n_fail++; $display("FAIL rmul%0d: got %b %h %h expected 1 %h %h", n, out_valid,
                                   res_v, dest_out, ref_vec(8, a, b, 21'h0), d);
            end
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; exc = '0; r1e = '0; r2e = '0;
        r1v = '0; r2v = '0; imm = '0; dest = '0; destType = 1'b0;
        test_reset();
        test_vec_add_carry();
        test_scalar_sub();
        test_vec_mul();
        test_mul_reset();
        test_addi_sll();
        test_reserved_and_toggle();
        test_back_to_back();
        test_random_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_exec_unit.md
VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 SHALL have parameter LANES, default 8, number of vector lanes.
REQ-002 SHALL have parameter LANE_W, default 24, lane width in bits (LANES*LANE_W = 192).
REQ-003 SHALL have port clk input 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst input 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid input 1: operation present on the inputs.
REQ-006 SHALL have port exc input 5: exc[4]=1 vector mode, 0 scalar mode; exc[3:0]=opcode.
REQ-007 SHALL have ports r1e, r2e input 21 each: scalar operands.
REQ-008 SHALL have ports r1v, r2v input 192 each: vector operands; lane i = bits [24i+23:24i].
REQ-009 SHALL have port imm input 21: immediate, two's complement.
REQ-010 SHALL have ports dest input 4 and destType input 1: destination tag, passed through.
REQ-011 SHALL have port stall output 1: upstream must hold all inputs while high.
REQ-012 SHALL have port out_valid output 1: result valid, one-cycle pulse per accepted operation.
REQ-013 SHALL have ports res_v output 192, res_e output 21, dest_out output 4, destType_out output 1.

Function
REQ-014 SHALL accept an operation on posedge when in_valid=1 and stall=0; inputs are ignored otherwise.
REQ-015 SHALL decode opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL by imm[4:0], 6 SRL (logical) by imm[4:0], 7 ADDI, 8 MUL, 9 PASS r1, 10-15 reserved.
REQ-016 SHALL compute vector-mode results lane-wise on r1v/r2v, modulo 2^24 per lane, with no carry between lanes; res_e = 0.
REQ-017 SHALL compute scalar-mode results on r1e/r2e modulo 2^21; res_v = 0.
REQ-018 SHALL, for ADDI, sign-extend imm to the lane width (vector mode) or use it as is (scalar mode) and add it to r1.
REQ-019 SHALL produce all-zero results for a shift amount >= 24 (vector mode) or >= 21 (scalar mode).
REQ-020 SHALL produce zero results with out_valid=1 for reserved opcodes.
REQ-021 SHALL register non-MUL results and scalar MUL: out_valid and results valid on the posedge following acceptance (latency 1), with stall=0 throughout.
REQ-022 SHALL run vector MUL on FSM IDLE -> MUL -> IDLE, keeping the low 24 bits of each lane product and processing 2 lanes per cycle (lanes 0-1 first), using a 2-bit lane-pair counter.
REQ-023 SHALL, on vector MUL acceptance, latch the operands, dest and destType and enter MUL; stall=1 combinationally while in MUL.
REQ-024 SHALL stay in MUL for 4 cycles; on the 4th posedge it returns to IDLE and asserts out_valid with the full res_v (latency 4).
REQ-025 SHALL accept a new operation on the posedge that immediately follows the MUL completion posedge.
REQ-026 SHALL register dest_out and destType_out from the accepted operation, updating them together with out_valid.
REQ-027 SHALL hold res_v, res_e, dest_out and destType_out at their last values when out_valid=0.
REQ-028 SHALL ignore in_valid while stall=1, with no queuing.

Reset
REQ-029 SHALL, while rst=0, force FSM=IDLE, counter=0, stall=0, out_valid=0, res_v=0, res_e=0, dest_out=0 and destType_out=0.
REQ-030 SHALL abort an in-progress MUL when rst is asserted mid-operation, without producing out_valid, and resume accepting operations on the first posedge after rst deasserts.

Verification
REQ-031 SHALL pass: vector ADD with every lane of r1v=0xFFFFFF and r2v=0x000001 -> every lane 0x000000, no cross-lane carry, out_valid one cycle later.
REQ-032 SHALL pass: scalar SUB with r1e=0, r2e=1 -> res_e=0x1FFFFF and res_v=0.
REQ-033 SHALL pass: vector MUL with lane i = i+1 in both operands -> stall high 4 cycles, then lane i = (i+1)^2, dest_out equal to the tag latched at acceptance.
REQ-034 SHALL pass: vector MUL accepted, rst low in its 2nd cycle -> no out_valid, all outputs 0, and a following ADD completes normally.
REQ-035 SHALL pass: vector ADDI with imm=0x1FFFFF (-1) on lanes=5 -> every lane 4; SLL with imm=24 -> all lanes 0.
REQ-036 SHALL pass: opcode 12 -> out_valid=1 with zero results; in_valid toggled during a MUL stall -> no extra out_valid.
